// File: rtl/imm_extend_pipe_pkg.sv
// Shared constants for the pipelined LEGv8 immediate generator.
package imm_pkg;

  localparam int INSTR_W = 26;
  localparam int CTRL_W  = 3;

  // Mode select encodings
  localparam logic [CTRL_W-1:0] IMM_I    = 3'b000;
  localparam logic [CTRL_W-1:0] IMM_D    = 3'b001;
  localparam logic [CTRL_W-1:0] IMM_B    = 3'b010;
  localparam logic [CTRL_W-1:0] IMM_CB   = 3'b011;
  localparam logic [CTRL_W-1:0] IMM_MOVZ = 3'b100;
  localparam logic [CTRL_W-1:0] IMM_MOVK = 3'b101;
  localparam logic [CTRL_W-1:0] IMM_BS   = 3'b110;
  localparam logic [CTRL_W-1:0] IMM_CBS  = 3'b111;

  // Field bit positions within instr[25:0]
  localparam int IMM12_MSB = 21, IMM12_LSB = 10;
  localparam int IMM9_MSB  = 20, IMM9_LSB  = 12;
  localparam int IMM26_MSB = 25, IMM26_LSB = 0;
  localparam int IMM19_MSB = 23, IMM19_LSB = 5;
  localparam int IMM16_MSB = 20, IMM16_LSB = 5;
  localparam int HW_MSB    = 22, HW_LSB    = 21;

  // Request captured in stage 1 (keep_val is width-parametric, held separately)
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [CTRL_W-1:0]  ctrl;
  } req_t;

  // A halfword slot beyond bit 31 does not exist on a 32-bit datapath
  function automatic logic is_illegal(input int data_w, input logic [CTRL_W-1:0] ctrl,
                                      input logic [1:0] hw);
    return (data_w == 32) && ((ctrl == IMM_MOVZ) || (ctrl == IMM_MOVK)) && hw[1];
  endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Request/response handshake bundle for imm_extend_pipe.
interface imm_extend_pipe_if #(parameter int DATA_W = 64);
  logic              in_valid;
  logic              in_ready;
  logic [25:0]       instr;
  logic [2:0]        ctrl;
  logic [DATA_W-1:0] keep_val;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] imm;
  logic              err;

  // master: decode-side producer plus execute-side consumer
  modport master (output in_valid, instr, ctrl, keep_val, out_ready,
                  input  in_ready, out_valid, imm, err);
  // slave: the immediate generator itself
  modport slave  (input  in_valid, instr, ctrl, keep_val, out_ready,
                  output in_ready, out_valid, imm, err);
endinterface

// File: rtl/imm_extend_pipe_core.sv
// Combinational immediate decode: field extract, extend, scale, MOVZ/MOVK insert.
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [CTRL_W-1:0]  ctrl,
  input  logic [DATA_W-1:0]  keep_val,
  output logic [DATA_W-1:0]  imm,
  output logic               illegal
);

  logic [11:0]       imm12;
  logic [8:0]        imm9;
  logic [25:0]       imm26;
  logic [18:0]       imm19;
  logic [15:0]       imm16;
  logic [1:0]        hw;
  logic [5:0]        sh;
  logic [DATA_W-1:0] sx9, sx19, sx26, ins16, mask16, res;

  assign imm12 = instr[IMM12_MSB:IMM12_LSB];
  assign imm9  = instr[IMM9_MSB:IMM9_LSB];
  assign imm26 = instr[IMM26_MSB:IMM26_LSB];
  assign imm19 = instr[IMM19_MSB:IMM19_LSB];
  assign imm16 = instr[IMM16_MSB:IMM16_LSB];
  assign hw    = instr[HW_MSB:HW_LSB];

  assign sx9  = {{(DATA_W-9){imm9[8]}},   imm9};
  assign sx19 = {{(DATA_W-19){imm19[18]}}, imm19};
  assign sx26 = {{(DATA_W-26){imm26[25]}}, imm26};

  // Halfword slot offset is 16*hw; slots past DATA_W shift out and are flagged illegal
  assign sh     = {hw, 4'b0000};
  assign ins16  = {{(DATA_W-16){1'b0}}, imm16} << sh;
  assign mask16 = {{(DATA_W-16){1'b0}}, 16'hFFFF} << sh;

  assign illegal = is_illegal(DATA_W, ctrl, hw);

  // Mode mux; scaled modes drop bits shifted past the top
  always_comb begin
    res = '0;
    case (ctrl)
      IMM_I:    res = {{(DATA_W-12){1'b0}}, imm12};
      IMM_D:    res = sx9;
      IMM_B:    res = sx26;
      IMM_CB:   res = sx19;
      IMM_MOVZ: res = ins16;
      IMM_MOVK: res = (keep_val & ~mask16) | ins16;
      IMM_BS:   res = sx26 << 2;
      IMM_CBS:  res = sx19 << 2;
    endcase
  end

  assign imm = illegal ? '0 : res;

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate generator with valid/ready on both sides and an
// illegal-request counter. S1 holds the raw request, S2 holds the result.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 8
) (
  input  logic             CLK,
  input  logic             resetl,
  imm_extend_pipe_if.slave bus,
  output logic [CNT_W-1:0] err_cnt
);

  if ((DATA_W != 32) && (DATA_W != 64)) begin : g_bad_width
    $error("imm_extend_pipe: DATA_W must be 32 or 64");
  end

  logic [2:1]        vld_pipe;
  req_t              s1_req;
  logic [DATA_W-1:0] s1_keep;
  logic [DATA_W-1:0] c_imm, s2_imm;
  logic              c_ill, s2_err;
  logic              accept, s2_load;

  // S2 refills whenever its slot is empty or draining this cycle
  assign s2_load      = vld_pipe[1] && (!vld_pipe[2] || bus.out_ready);
  assign bus.in_ready = !vld_pipe[1] || s2_load;
  assign accept       = bus.in_valid && bus.in_ready;

  imm_extend_core #(.DATA_W(DATA_W)) u_core (
    .instr   (s1_req.instr),
    .ctrl    (s1_req.ctrl),
    .keep_val(s1_keep),
    .imm     (c_imm),
    .illegal (c_ill)
  );

  // Stage registers: S1 captures request (incl. keep_val), S2 captures result
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      vld_pipe <= '0;
      s1_req   <= '0;
      s1_keep  <= '0;
      s2_imm   <= '0;
      s2_err   <= 1'b0;
    end else begin
      if (accept) begin
        vld_pipe[1]  <= 1'b1;
        s1_req.instr <= bus.instr;
        s1_req.ctrl  <= bus.ctrl;
        s1_keep      <= bus.keep_val;
      end else if (s2_load) begin
        vld_pipe[1]  <= 1'b0;
      end
      if (s2_load) begin
        vld_pipe[2] <= 1'b1;
        s2_imm      <= c_imm;
        s2_err      <= c_ill;
      end else if (bus.out_ready) begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end

  // Saturating count of illegal requests, bumped at acceptance
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      err_cnt <= '0;
    end else if (accept && is_illegal(DATA_W, bus.ctrl, bus.instr[HW_MSB:HW_LSB])
                 && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign bus.out_valid = vld_pipe[2];
  assign bus.imm       = s2_imm;
  assign bus.err       = s2_err;

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate generator for the LEGv8 datapath, succeeding the combinational sign extender. It decodes I/D/B/CB immediates, MOVZ, and MOVK halfword insertion, plus word-scaled branch offsets, for a configurable datapath width. A valid/ready handshake sits on each side, so it can be placed between decode and execute in the pipelined core. It flags and counts illegal requests.

## Interface
- `DATA_W`, default 64: output width. Legal values are 32 and 64; any other value is an elaboration error.
- `CNT_W`, default 8: width of the saturating illegal-request counter.
- `CLK` in 1: clock; all state updates on the rising edge.
- `resetl` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block accepts a request this cycle.
- `instr` in 26: `instr[25:0]` of the instruction.
- `ctrl` in 3: mode select (see Operation).
- `keep_val` in DATA_W: current destination register value; used only by MOVK.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `imm` out DATA_W: result.
- `err` out 1: result belongs to an illegal request; qualified by `out_valid`.
- `err_cnt` out CNT_W: count of accepted illegal requests; saturates at all-ones.

## Operation
- Field extraction:
  - imm12 = `instr[21:10]`
  - imm9 = `instr[20:12]`
  - imm26 = `instr[25:0]`
  - imm19 = `instr[23:5]`
  - imm16 = `instr[20:5]`
  - hw = `instr[22:21]`
- Modes by `ctrl`:
  - 000 I-type: zero-extend imm12.
  - 001 D-type: sign-extend imm9.
  - 010 B-type: sign-extend imm26.
  - 011 CB-type: sign-extend imm19.
  - 100 MOVZ: imm16 shifted left by 16·hw; all other bits zero.
  - 101 MOVK: `keep_val` with bits [16·hw+15 : 16·hw] replaced by imm16.
  - 110 B-scaled: sign-extend imm26, then shift left by 2.
  - 111 CB-scaled: sign-extend imm19, then shift left by 2.
- Sign extension fills up to DATA_W. For scaled modes, bits shifted past DATA_W−1 are discarded.
- Illegal request: `DATA_W`=32 with `ctrl` 100/101 and hw ≥ 2. Result is `imm`=0 with `err`=1.
- `err_cnt` increments when an illegal request is accepted into stage 1. It holds at all-ones once saturated.
- `keep_val` is sampled with the request at acceptance. It is not re-read later.

## Timing
- Pipeline: stage S1 registers `instr`, `ctrl` and `keep_val`. Stage S2 registers the computed `imm`/`err`. Latency is exactly 2 cycles from acceptance to `out_valid` when there is no backpressure.
- Acceptance: the request is accepted on a rising edge where `in_valid` && `in_ready`.
- Stage advance:
  - s2_load = s1_valid && (!out_valid || out_ready)
  - `in_ready` = !s1_valid || s2_load (combinational)
- Throughput: one result per cycle under continuous `out_ready`=1.
- Backpressure:
  - While `out_valid` && !`out_ready`: `imm` and `err` hold stable, and S1 holds its contents.
  - When both stages are full, `in_ready`=0.
- Simultaneous events: when a result drains and a new request is accepted in the same cycle, both happen with no bubble.
- Reset: asserting `resetl`=0 at any time (including mid-transfer) immediately clears:
  - S1/S2 valid flags
  - `out_valid`=0, `imm`=0, `err`=0, `err_cnt`=0
- During reset, `in_ready` is 1. In-flight requests are dropped, not completed.

## Structure
- Package `imm_pkg`:
  - ctrl mode localparams (`IMM_I`, `IMM_D`, `IMM_B`, `IMM_CB`, `IMM_MOVZ`, `IMM_MOVK`, `IMM_BS`, `IMM_CBS`)
  - field bit-position constants
- Sub-module `imm_extend_core`: purely combinational compute, taking (`instr`, `ctrl`, `keep_val`) and producing (`imm`, `illegal`), parametrised by `DATA_W`. It is instantiated between S1 and S2.
- The top level holds the handshake, stage registers and counter.

## Test plan
- D-type, `instr[20:12]`=0x1FF, `DATA_W`=64 → `imm`=0xFFFF_FFFF_FFFF_FFFF, arriving 2 cycles after acceptance; `err`=0.
- MOVZ with imm16=0x1234, hw=01 → 0x0000_0000_1234_0000. MOVK with imm16=0xBEEF, hw=11, `keep_val`=0x0123_4567_89AB_CDEF → 0xBEEF_4567_89AB_CDEF.
- CB-scaled with imm19=0x7FFFF → 0xFFFF_FFFF_FFFF_FFFC. B-scaled with imm26=0x0000001 → 0x4.
- `DATA_W`=32, MOVZ hw=10 → `imm`=0, `err`=1, `err_cnt` 0→1. After 300 illegal requests with `CNT_W`=8, `err_cnt`=0xFF.
- Streaming 4 back-to-back requests:
  - hold `out_ready`=0 for 3 cycles → `in_ready` drops after the second accept, and `imm` stays stable;
  - release → all 4 results appear in order with no loss or duplication.
- Assert `resetl`=0 with both stages full → `out_valid`=0 immediately. After release, there is no stale output and the first new request emerges at exactly 2-cycle latency.
